tl_addr_router: RTL and testbench
=================================

TL_ADDR_ROUTER -- requirements
Module: tl_addr_router

Interface
- REQ-001 Parameters, one per line:
  - MAP_BASE, 14'h1000, first address of the mapped target window.
  - MAP_SIZE, 14'h1000, window length in bytes.
  - A request is mapped iff MAP_BASE <= address < MAP_BASE+MAP_SIZE, computed at 15 bits.
- REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
  - clock  input  1  sole clock; all state updates on its rising edge.
  - reset  input  1  synchronous, active-low; state is cleared when reset==0 at a rising clock edge.
- REQ-003 Upstream ports:
  - auto_in_a_{valid,opcode[2:0],param[2:0],size[3:0],source[4:0],address[13:0],mask[3:0],data[31:0],corrupt}  input  as listed  upstream A-channel request.
  - auto_in_a_ready  output  1  A-channel accept.
  - auto_in_d_ready  input  1  upstream D-channel accept.
  - auto_in_d_{valid,opcode[2:0],param[1:0],size[3:0],source[4:0],sink,denied,data[31:0],corrupt}  output  as listed  merged D-channel response.
- REQ-004 Target-side ports:
  - auto_out_a_*  output  same widths as auto_in_a_*  A-channel to the mapped target.
  - auto_out_a_ready  input  1  target A-channel accept.
  - auto_out_d_*  input  same widths as auto_in_d_*  full D-channel response from the target.
  - auto_out_d_ready  output  1  target D-channel accept.
- REQ-005 Error-side ports:
  - auto_err_a_{valid,opcode,param,size,source,address,mask,corrupt}  output  as auto_in_a_*  A-channel to the error device; no data field.
  - auto_err_a_ready  input  1  error device A-channel accept.
  - auto_err_d_{valid,opcode,size,source,corrupt}  input  as auto_in_d_*  reduced D-channel response from the error device.
  - auto_err_d_ready  output  1  error device D-channel accept.
- REQ-006 err_count  output  16  number of requests routed to the error port (see Configuration).

Function
- REQ-007 The A path SHALL be combinational pass-through with zero latency.
  - in_a_ready = ready of the selected port.
  - Only the selected port's a_valid may be high.
  - Fields are copied unchanged.
- REQ-008 The route SHALL be decided on the first beat of each A message and held until that message's last beat.
- REQ-009 A message beat count:
  - opcode 0 or 1 with size>2: 2^(size-2) beats, counted by a 5-bit counter.
  - All other cases: one beat.
- REQ-010 D arbiter states: IDLE, LOCK_T, LOCK_E.
  - In IDLE, a single valid source is granted.
  - When both sources are valid, grant follows a round-robin pointer that toggles after each granted message; the pointer resets to the target port.
- REQ-011 D beat count and lock:
  - opcode 1 with size>2: 2^(size-2) beats.
  - Otherwise: one beat.
  - The arbiter SHALL stay in LOCK_* until the last beat fires, then return to IDLE in the same edge.
- REQ-012 The D output SHALL be combinational from the granted source, including in IDLE.
  - The non-granted source's d_ready is 0.
  - The granted source's d_ready = auto_in_d_ready.
- REQ-013 Error-sourced responses SHALL drive:
  - param=0, sink=0, denied=1, data=32'h0.
  - opcode, size, source and corrupt taken from auto_err_d_*.
- REQ-014 A-channel boundary case: a mapped message whose first address is mapped SHALL go wholly to the target, even if later beats cross MAP_BASE+MAP_SIZE.
- REQ-015 D-channel boundary case: a D beat and an A beat firing in the same cycle are independent; neither stalls the other.

Reset
- REQ-016 While reset==0, all A and D valid and ready outputs SHALL be 0.
- REQ-017 On reset:
  - Both beat counters clear to 0.
  - The arbiter enters IDLE.
  - The round-robin pointer selects the target port.
  - err_count clears to 0.
- REQ-018 Reset asserted mid-message SHALL abandon the message; the first post-reset beat is treated as a new first beat.

Configuration
- REQ-019 Macro TL_ADDR_ROUTER_ERRCNT_EN controls err_count.
  - Defined: err_count increments by 1 on each first beat routed to the error port and saturates at 16'hFFFF.
  - Undefined: err_count is tied to 16'h0 and no counter register exists.

Verification
- REQ-020 Get, address 14'h1004, size 2 -> auto_out_a_valid=1, auto_err_a_valid=0; target D beat with data 32'hDEADBEEF reaches auto_in_d unchanged.
- REQ-021 Get, address 14'h3000 -> error port selected; response has denied=1, data=0, err_count=1 (macro defined) or 0 (undefined).
- REQ-022 PutFullData, size 4, address 14'h1FF8 -> all 4 beats go to the target port; route holds with auto_out_a_ready toggling.
- REQ-023 Target and error D valid in the same cycle from IDLE -> target granted first, error granted second; an 8-beat target AccessAckData (size 5) is not interleaved.
- REQ-024 reset=0 after the 2nd of 4 A beats -> outputs low; after release, a Get to 14'h0000 routes to the error port.

Source files
------------

// File: rtl/tl_addr_router_if.sv
// tl_addr_router_if -- bundle of the three TileLink-style ports of the router.
// slave  : the router's view (drives in_a ready, in_d response, out/err A, out/err D ready).
// master : the surrounding environment's view (the mirror image).
interface tl_addr_router_if;
  // upstream A
  logic        auto_in_a_valid;
  logic        auto_in_a_ready;
  logic [2:0]  auto_in_a_opcode;
  logic [2:0]  auto_in_a_param;
  logic [3:0]  auto_in_a_size;
  logic [4:0]  auto_in_a_source;
  logic [13:0] auto_in_a_address;
  logic [3:0]  auto_in_a_mask;
  logic [31:0] auto_in_a_data;
  logic        auto_in_a_corrupt;
  // upstream D
  logic        auto_in_d_valid;
  logic        auto_in_d_ready;
  logic [2:0]  auto_in_d_opcode;
  logic [1:0]  auto_in_d_param;
  logic [3:0]  auto_in_d_size;
  logic [4:0]  auto_in_d_source;
  logic        auto_in_d_sink;
  logic        auto_in_d_denied;
  logic [31:0] auto_in_d_data;
  logic        auto_in_d_corrupt;
  // target A
  logic        auto_out_a_valid;
  logic        auto_out_a_ready;
  logic [2:0]  auto_out_a_opcode;
  logic [2:0]  auto_out_a_param;
  logic [3:0]  auto_out_a_size;
  logic [4:0]  auto_out_a_source;
  logic [13:0] auto_out_a_address;
  logic [3:0]  auto_out_a_mask;
  logic [31:0] auto_out_a_data;
  logic        auto_out_a_corrupt;
  // target D
  logic        auto_out_d_valid;
  logic        auto_out_d_ready;
  logic [2:0]  auto_out_d_opcode;
  logic [1:0]  auto_out_d_param;
  logic [3:0]  auto_out_d_size;
  logic [4:0]  auto_out_d_source;
  logic        auto_out_d_sink;
  logic        auto_out_d_denied;
  logic [31:0] auto_out_d_data;
  logic        auto_out_d_corrupt;
  // error A (no data)
  logic        auto_err_a_valid;
  logic        auto_err_a_ready;
  logic [2:0]  auto_err_a_opcode;
  logic [2:0]  auto_err_a_param;
  logic [3:0]  auto_err_a_size;
  logic [4:0]  auto_err_a_source;
  logic [13:0] auto_err_a_address;
  logic [3:0]  auto_err_a_mask;
  logic        auto_err_a_corrupt;
  // error D (reduced)
  logic        auto_err_d_valid;
  logic        auto_err_d_ready;
  logic [2:0]  auto_err_d_opcode;
  logic [3:0]  auto_err_d_size;
  logic [4:0]  auto_err_d_source;
  logic        auto_err_d_corrupt;

  modport slave (
    input  auto_in_a_valid, auto_in_a_opcode, auto_in_a_param, auto_in_a_size, auto_in_a_source,
           auto_in_a_address, auto_in_a_mask, auto_in_a_data, auto_in_a_corrupt,
    output auto_in_a_ready,
    input  auto_in_d_ready,
    output auto_in_d_valid, auto_in_d_opcode, auto_in_d_param, auto_in_d_size, auto_in_d_source,
           auto_in_d_sink, auto_in_d_denied, auto_in_d_data, auto_in_d_corrupt,
    output auto_out_a_valid, auto_out_a_opcode, auto_out_a_param, auto_out_a_size, auto_out_a_source,
           auto_out_a_address, auto_out_a_mask, auto_out_a_data, auto_out_a_corrupt,
    input  auto_out_a_ready,
    input  auto_out_d_valid, auto_out_d_opcode, auto_out_d_param, auto_out_d_size, auto_out_d_source,
           auto_out_d_sink, auto_out_d_denied, auto_out_d_data, auto_out_d_corrupt,
    output auto_out_d_ready,
    output auto_err_a_valid, auto_err_a_opcode, auto_err_a_param, auto_err_a_size, auto_err_a_source,
           auto_err_a_address, auto_err_a_mask, auto_err_a_corrupt,
    input  auto_err_a_ready,
    input  auto_err_d_valid, auto_err_d_opcode, auto_err_d_size, auto_err_d_source, auto_err_d_corrupt,
    output auto_err_d_ready
  );

  modport master (
    output auto_in_a_valid, auto_in_a_opcode, auto_in_a_param, auto_in_a_size, auto_in_a_source,
           auto_in_a_address, auto_in_a_mask, auto_in_a_data, auto_in_a_corrupt,
    input  auto_in_a_ready,
    output auto_in_d_ready,
    input  auto_in_d_valid, auto_in_d_opcode, auto_in_d_param, auto_in_d_size, auto_in_d_source,
           auto_in_d_sink, auto_in_d_denied, auto_in_d_data, auto_in_d_corrupt,
    input  auto_out_a_valid, auto_out_a_opcode, auto_out_a_param, auto_out_a_size, auto_out_a_source,
           auto_out_a_address, auto_out_a_mask, auto_out_a_data, auto_out_a_corrupt,
    output auto_out_a_ready,
    output auto_out_d_valid, auto_out_d_opcode, auto_out_d_param, auto_out_d_size, auto_out_d_source,
           auto_out_d_sink, auto_out_d_denied, auto_out_d_data, auto_out_d_corrupt,
    input  auto_out_d_ready,
    input  auto_err_a_valid, auto_err_a_opcode, auto_err_a_param, auto_err_a_size, auto_err_a_source,
           auto_err_a_address, auto_err_a_mask, auto_err_a_corrupt,
    output auto_err_a_ready,
    output auto_err_d_valid, auto_err_d_opcode, auto_err_d_size, auto_err_d_source, auto_err_d_corrupt,
    input  auto_err_d_ready
  );
endinterface

// File: rtl/tl_addr_router.sv
// tl_addr_router -- routes upstream A requests to a mapped target window or to an
// error device, and merges both D response streams back upstream with a
// message-locked round-robin arbiter.
// Optional feature: define TL_ADDR_ROUTER_ERRCNT_EN to get a saturating count of
// requests sent to the error device on err_count (otherwise tied to zero).
module tl_addr_router #(
  parameter logic [13:0] MAP_BASE = 14'h1000,
  parameter logic [13:0] MAP_SIZE = 14'h1000
) (
  input  logic               clock,
  input  logic               reset,   // synchronous, active-low
  tl_addr_router_if.slave    bus,
  output logic [15:0]        err_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_T = 2'd1;
  localparam logic [1:0] LOCK_E = 2'd2;

  // ---------------------------------------------------------------- A path
  logic [14:0] map_lo, map_hi, addr_ext;
  logic        addr_mapped;
  logic [4:0]  a_cnt;        // beats still to come in the current message
  logic        route_err_q;  // route latched on the first beat
  logic        a_first, sel_err, a_fire, a_multi;
  logic [4:0]  a_beats_m1;

  assign map_lo      = {1'b0, MAP_BASE};
  assign map_hi      = {1'b0, MAP_BASE} + {1'b0, MAP_SIZE};
  assign addr_ext    = {1'b0, bus.auto_in_a_address};
  assign addr_mapped = (addr_ext >= map_lo) && (addr_ext < map_hi);

  assign a_first    = (a_cnt == 5'd0);
  assign sel_err    = a_first ? ~addr_mapped : route_err_q;
  assign a_multi    = (bus.auto_in_a_opcode <= 3'd1) && (bus.auto_in_a_size > 4'd2);
  assign a_beats_m1 = a_multi ? 5'((32'd1 << (bus.auto_in_a_size - 4'd2)) - 32'd1) : 5'd0;

  assign bus.auto_in_a_ready  = reset & (sel_err ? bus.auto_err_a_ready : bus.auto_out_a_ready);
  assign a_fire               = bus.auto_in_a_valid & bus.auto_in_a_ready;

  assign bus.auto_out_a_valid   = reset & bus.auto_in_a_valid & ~sel_err;
  assign bus.auto_out_a_opcode  = bus.auto_in_a_opcode;
  assign bus.auto_out_a_param   = bus.auto_in_a_param;
  assign bus.auto_out_a_size    = bus.auto_in_a_size;
  assign bus.auto_out_a_source  = bus.auto_in_a_source;
  assign bus.auto_out_a_address = bus.auto_in_a_address;
  assign bus.auto_out_a_mask    = bus.auto_in_a_mask;
  assign bus.auto_out_a_data    = bus.auto_in_a_data;
  assign bus.auto_out_a_corrupt = bus.auto_in_a_corrupt;

  assign bus.auto_err_a_valid   = reset & bus.auto_in_a_valid & sel_err;
  assign bus.auto_err_a_opcode  = bus.auto_in_a_opcode;
  assign bus.auto_err_a_param   = bus.auto_in_a_param;
  assign bus.auto_err_a_size    = bus.auto_in_a_size;
  assign bus.auto_err_a_source  = bus.auto_in_a_source;
  assign bus.auto_err_a_address = bus.auto_in_a_address;
  assign bus.auto_err_a_mask    = bus.auto_in_a_mask;
  assign bus.auto_err_a_corrupt = bus.auto_in_a_corrupt;

  // Track A message beats and hold the route chosen on the first beat.
  always_ff @(posedge clock) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (!reset) begin
      a_cnt       <= 5'd0;
      route_err_q <= 1'b0;
    end else if (a_fire) begin
      if (a_first) begin
        a_cnt       <= a_beats_m1;
        route_err_q <= ~addr_mapped;
      end else begin
        a_cnt <= a_cnt - 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------- D path
  logic [1:0] d_state;
  logic       rr_ptr;        // 0: target preferred on a tie, 1: error preferred
  logic [4:0] d_cnt;         // beats still to come while locked
  logic       grant_e, d_fire, d_multi;
  logic [2:0] d_opcode;
  logic [3:0] d_size;
  logic [4:0] d_beats_m1;

  // Pick the granted source: fixed while locked, single/round-robin in IDLE.
  always_comb begin
    // NOTE: default first so no path through the case leaves grant_e unassigned (no latch).
    grant_e = 1'b0;
    case (d_state)
      LOCK_T:  grant_e = 1'b0;
      LOCK_E:  grant_e = 1'b1;
      default: begin
        if (bus.auto_err_d_valid && !bus.auto_out_d_valid)
          grant_e = 1'b1;
        else if (bus.auto_err_d_valid && bus.auto_out_d_valid)
          grant_e = rr_ptr;
      end
    endcase
  end

  assign d_opcode   = grant_e ? bus.auto_err_d_opcode : bus.auto_out_d_opcode;
  assign d_size     = grant_e ? bus.auto_err_d_size   : bus.auto_out_d_size;
  assign d_multi    = (d_opcode == 3'd1) && (d_size > 4'd2);
  assign d_beats_m1 = d_multi ? 5'((32'd1 << (d_size - 4'd2)) - 32'd1) : 5'd0;

  assign bus.auto_in_d_valid   = reset & (grant_e ? bus.auto_err_d_valid : bus.auto_out_d_valid);
  assign bus.auto_in_d_opcode  = d_opcode;
  assign bus.auto_in_d_size    = d_size;
  assign bus.auto_in_d_param   = grant_e ? 2'd0  : bus.auto_out_d_param;
  assign bus.auto_in_d_source  = grant_e ? bus.auto_err_d_source  : bus.auto_out_d_source;
  assign bus.auto_in_d_sink    = grant_e ? 1'b0  : bus.auto_out_d_sink;
  assign bus.auto_in_d_denied  = grant_e ? 1'b1  : bus.auto_out_d_denied;
  assign bus.auto_in_d_data    = grant_e ? 32'h0 : bus.auto_out_d_data;
  assign bus.auto_in_d_corrupt = grant_e ? bus.auto_err_d_corrupt : bus.auto_out_d_corrupt;

  assign bus.auto_out_d_ready = reset & ~grant_e & bus.auto_in_d_ready;
  assign bus.auto_err_d_ready = reset &  grant_e & bus.auto_in_d_ready;
  assign d_fire               = bus.auto_in_d_valid & bus.auto_in_d_ready;

  // Lock the arbiter for multi-beat responses; flip the pointer when a message ends.
  always_ff @(posedge clock) begin
    if (!reset) begin
      d_state <= IDLE;
      rr_ptr  <= 1'b0;
      d_cnt   <= 5'd0;
    end else if (d_fire) begin
      if (d_state == IDLE) begin
        if (d_beats_m1 != 5'd0) begin
          d_state <= grant_e ? LOCK_E : LOCK_T;
          d_cnt   <= d_beats_m1;
        end else begin
          rr_ptr <= ~rr_ptr;
        end
      end else begin
        d_cnt <= d_cnt - 5'd1;
        if (d_cnt == 5'd1) begin
          d_state <= IDLE;
          rr_ptr  <= ~rr_ptr;
        end
      end
    end
  end

  // ---------------------------------------------------------------- error count
`ifdef TL_ADDR_ROUTER_ERRCNT_EN
  logic [15:0] err_count_q;

  // Count first beats sent to the error device, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (!reset)
      err_count_q <= 16'h0;
    else if (a_fire && a_first && sel_err && (err_count_q != 16'hFFFF))
      err_count_q <= err_count_q + 16'd1;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_tl_addr_router.sv
// tb_tl_addr_router -- self-checking bench for tl_addr_router: a table of
// single-beat routing vectors, hand-written multi-cycle sequences, then a
// randomized run against a message-level reference model.
module tb_tl_addr_router;

`ifdef TL_ADDR_ROUTER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] err_count;
  int          tests = 0;
  int          fails = 0;

  tl_addr_router_if bus ();

  tl_addr_router dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.auto_in_a_valid = 0; bus.auto_in_a_opcode = 0; bus.auto_in_a_param = 0;
    bus.auto_in_a_size = 0; bus.auto_in_a_source = 0; bus.auto_in_a_address = 0;
    bus.auto_in_a_mask = 4'hF; bus.auto_in_a_data = 0; bus.auto_in_a_corrupt = 0;
    bus.auto_in_d_ready = 0;
    bus.auto_out_a_ready = 0; bus.auto_err_a_ready = 0;
    bus.auto_out_d_valid = 0; bus.auto_out_d_opcode = 0; bus.auto_out_d_param = 0;
    bus.auto_out_d_size = 0; bus.auto_out_d_source = 0; bus.auto_out_d_sink = 0;
    bus.auto_out_d_denied = 0; bus.auto_out_d_data = 0; bus.auto_out_d_corrupt = 0;
    bus.auto_err_d_valid = 0; bus.auto_err_d_opcode = 0; bus.auto_err_d_size = 0;
    bus.auto_err_d_source = 0; bus.auto_err_d_corrupt = 0;
  endtask

  task automatic reset_dut();
    @(negedge clock);
    clear_inputs();
    reset = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  function automatic bit is_mapped(input int addr);
    return (addr >= 'h1000) && (addr < 'h1000 + 'h1000);
  endfunction

  function automatic int a_beats(input int op, input int sz);
    return (op <= 1 && sz > 2) ? (1 << (sz - 2)) : 1;
  endfunction

  function automatic int d_beats(input int op, input int sz);
    return (op == 1 && sz > 2) ? (1 << (sz - 2)) : 1;
  endfunction

  typedef struct {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [13:0] addr;
    logic        out_rdy;
    logic        err_rdy;
    logic        exp_out_v;
    logic        exp_err_v;
    logic        exp_in_rdy;
    logic [15:0] exp_cnt;   // error count after the edge when counting is enabled
  } a_vec_t;

  a_vec_t vecs[9];

  // random-phase model state
  int a_rem, d_rem, d_owner;
  bit a_held_err, rr;
  int m_cnt;

  initial begin
    clear_inputs();

    // ---- reset state: outputs forced low even with every valid/ready asserted
    bus.auto_in_a_valid = 1; bus.auto_in_a_address = 14'h1004; bus.auto_out_a_ready = 1;
    bus.auto_err_a_ready = 1; bus.auto_out_d_valid = 1; bus.auto_err_d_valid = 1;
    bus.auto_in_d_ready = 1;
    @(negedge clock); #1;
    check("rst_in_a_ready",  bus.auto_in_a_ready,  0);
    check("rst_out_a_valid", bus.auto_out_a_valid, 0);
    check("rst_err_a_valid", bus.auto_err_a_valid, 0);
    check("rst_in_d_valid",  bus.auto_in_d_valid,  0);
    check("rst_d_readies",   {bus.auto_out_d_ready, bus.auto_err_d_ready}, 0);
    @(posedge clock); #1;
    check("rst_err_count", err_count, 0);
    reset_dut();

    // ---- table-driven single-beat routing vectors
    vecs[0] = '{3'd4, 4'd2, 14'h1004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[1] = '{3'd4, 4'd2, 14'h3000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[2] = '{3'd4, 4'd2, 14'h3000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
    vecs[3] = '{3'd4, 4'd2, 14'h0FFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[4] = '{3'd4, 4'd2, 14'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
    vecs[5] = '{3'd4, 4'd2, 14'h1FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[6] = '{3'd4, 4'd2, 14'h2000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3};
    vecs[7] = '{3'd0, 4'd2, 14'h1800, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3};
    vecs[8] = '{3'd1, 4'd1, 14'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4};
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      bus.auto_in_a_valid   = 1;
      bus.auto_in_a_opcode  = vecs[i].opcode;
      bus.auto_in_a_size    = vecs[i].size;
      bus.auto_in_a_address = vecs[i].addr;
      bus.auto_in_a_source  = 5'(i);
      bus.auto_in_a_data    = 32'hA5000000 + i;
      bus.auto_out_a_ready  = vecs[i].out_rdy;
      bus.auto_err_a_ready  = vecs[i].err_rdy;
      #1;
      check($sformatf("vec%0d_valids", i), {bus.auto_out_a_valid, bus.auto_err_a_valid},
            {vecs[i].exp_out_v, vecs[i].exp_err_v});
      check($sformatf("vec%0d_in_ready", i), bus.auto_in_a_ready, vecs[i].exp_in_rdy);
      check($sformatf("vec%0d_fields", i),
            {bus.auto_out_a_address, bus.auto_err_a_source, bus.auto_out_a_data},
            {vecs[i].addr, 5'(i), 32'hA5000000 + 32'(i)});
      @(posedge clock); #1;
      check($sformatf("vec%0d_err_count", i), err_count, CNT_EN ? vecs[i].exp_cnt : 16'd0);
    end

    // ---- target D beat passes through unchanged
    reset_dut();
    @(negedge clock);
    bus.auto_in_d_ready = 1; bus.auto_out_d_valid = 1; bus.auto_out_d_opcode = 3'd1;
    bus.auto_out_d_size = 4'd2; bus.auto_out_d_source = 5'd5; bus.auto_out_d_data = 32'hDEADBEEF;
    #1;
    check("tgt_d_valid",  bus.auto_in_d_valid, 1);
    check("tgt_d_data",   bus.auto_in_d_data, 32'hDEADBEEF);
    check("tgt_d_fields", {bus.auto_in_d_opcode, bus.auto_in_d_source, bus.auto_in_d_denied}, {3'd1, 5'd5, 1'b0});
    check("tgt_d_ready",  {bus.auto_out_d_ready, bus.auto_err_d_ready}, 2'b10);

    // ---- error D beat is denied with zero data
    @(negedge clock);
    bus.auto_out_d_valid = 0; bus.auto_err_d_valid = 1; bus.auto_err_d_opcode = 3'd1;
    bus.auto_err_d_size = 4'd2; bus.auto_err_d_source = 5'd6; bus.auto_err_d_corrupt = 1;
    #1;
    check("err_d_valid",  bus.auto_in_d_valid, 1);
    check("err_d_fixed",  {bus.auto_in_d_denied, bus.auto_in_d_data, bus.auto_in_d_param, bus.auto_in_d_sink},
          {1'b1, 32'h0, 2'd0, 1'b0});
    check("err_d_fields", {bus.auto_in_d_opcode, bus.auto_in_d_source, bus.auto_in_d_corrupt}, {3'd1, 5'd6, 1'b1});
    check("err_d_ready",  {bus.auto_out_d_ready, bus.auto_err_d_ready}, 2'b01);

    // ---- 4-beat put crossing the window end stays on the target, ready toggling
    reset_dut();
    begin
      int fired = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        bus.auto_in_a_valid = 1; bus.auto_in_a_opcode = 3'd0; bus.auto_in_a_size = 4'd4;
        bus.auto_in_a_address = 14'(14'h1FF8 + 4 * fired);
        bus.auto_out_a_ready = c[0]; bus.auto_err_a_ready = 1;
        #1;
        check($sformatf("put_beat%0d_route", fired), {bus.auto_out_a_valid, bus.auto_err_a_valid}, 2'b10);
        check($sformatf("put_cyc%0d_ready", c), bus.auto_in_a_ready, c[0]);
        @(posedge clock);
        if (c[0]) fired++;
      end
      @(negedge clock);
      bus.auto_in_a_opcode = 3'd4; bus.auto_in_a_size = 4'd2; bus.auto_in_a_address = 14'h2008;
      #1;
      check("after_put_route", {bus.auto_out_a_valid, bus.auto_err_a_valid}, 2'b01);
    end

    // ---- simultaneous D valids: target first, 8-beat burst not interleaved, then error
    reset_dut();
    for (int b = 0; b < 8; b++) begin
      @(negedge clock);
      bus.auto_in_d_ready = 1;
      bus.auto_out_d_valid = 1; bus.auto_out_d_opcode = 3'd1; bus.auto_out_d_size = 4'd5;
      bus.auto_out_d_source = 5'd7; bus.auto_out_d_data = 32'h100 + b;
      bus.auto_err_d_valid = 1; bus.auto_err_d_opcode = 3'd0; bus.auto_err_d_size = 4'd2;
      bus.auto_err_d_source = 5'd9;
      #1;
      check($sformatf("burst%0d_src", b), {bus.auto_in_d_source, bus.auto_in_d_data}, {5'd7, 32'h100 + 32'(b)});
      check($sformatf("burst%0d_rdy", b), {bus.auto_out_d_ready, bus.auto_err_d_ready}, 2'b10);
      @(posedge clock);
    end
    @(negedge clock); #1;
    check("rr_err_src", {bus.auto_in_d_source, bus.auto_in_d_denied}, {5'd9, 1'b1});
    check("rr_err_rdy", {bus.auto_out_d_ready, bus.auto_err_d_ready}, 2'b01);

    // ---- reset in the middle of a 4-beat put abandons it
    reset_dut();
    for (int b = 0; b < 2; b++) begin
      @(negedge clock);
      bus.auto_in_a_valid = 1; bus.auto_in_a_opcode = 3'd0; bus.auto_in_a_size = 4'd4;
      bus.auto_in_a_address = 14'(14'h1000 + 4 * b); bus.auto_out_a_ready = 1; bus.auto_err_a_ready = 1;
      @(posedge clock);
    end
    @(negedge clock);
    reset = 0;
    bus.auto_out_d_valid = 1; bus.auto_err_d_valid = 1; bus.auto_in_d_ready = 1;
    #1;
    check("midrst_a", {bus.auto_in_a_ready, bus.auto_out_a_valid, bus.auto_err_a_valid}, 3'b000);
    check("midrst_d", {bus.auto_in_d_valid, bus.auto_out_d_ready, bus.auto_err_d_ready}, 3'b000);
    @(negedge clock);
    reset = 1;
    bus.auto_out_d_valid = 0; bus.auto_err_d_valid = 0;
    bus.auto_in_a_opcode = 3'd4; bus.auto_in_a_size = 4'd2; bus.auto_in_a_address = 14'h0000;
    #1;
    check("postrst_route", {bus.auto_out_a_valid, bus.auto_err_a_valid}, 2'b01);
    @(posedge clock); #1;
    check("postrst_err_count", err_count, CNT_EN ? 16'd1 : 16'd0);

    // ---- randomized run against a message-level model
    reset_dut();
    a_rem = 0; a_held_err = 0; d_rem = 0; d_owner = -1; rr = 0; m_cnt = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int  op, sz, addr, dop, dsz, eop, esz, g;
      bit  in_v, o_r, e_r, tv, ev, dr, err_sel, exp_rdy, exp_dv, a_fire_m;
      @(negedge clock);
      op = $urandom_range(0, 7); sz = $urandom_range(0, 5); addr = $urandom_range(0, 'h3FFF);
      in_v = ($urandom_range(0, 3) != 0); o_r = $urandom_range(0, 1); e_r = $urandom_range(0, 1);
      dop = $urandom_range(0, 2); dsz = $urandom_range(0, 5);
      eop = $urandom_range(0, 2); esz = $urandom_range(0, 5);
      tv = $urandom_range(0, 1); ev = $urandom_range(0, 1); dr = ($urandom_range(0, 3) != 0);
      bus.auto_in_a_valid = in_v; bus.auto_in_a_opcode = 3'(op); bus.auto_in_a_size = 4'(sz);
      bus.auto_in_a_address = 14'(addr); bus.auto_out_a_ready = o_r; bus.auto_err_a_ready = e_r;
      bus.auto_out_d_valid = tv; bus.auto_out_d_opcode = 3'(dop); bus.auto_out_d_size = 4'(dsz);
      bus.auto_out_d_source = 5'd3; bus.auto_out_d_data = $urandom;
      bus.auto_err_d_valid = ev; bus.auto_err_d_opcode = 3'(eop); bus.auto_err_d_size = 4'(esz);
      bus.auto_err_d_source = 5'd17; bus.auto_in_d_ready = dr;
      #1;
      // A side expectation
      err_sel = (a_rem == 0) ? !is_mapped(addr) : a_held_err;
      exp_rdy = err_sel ? e_r : o_r;
      check("rand_a", {bus.auto_out_a_valid, bus.auto_err_a_valid, bus.auto_in_a_ready},
            {in_v & !err_sel, in_v & err_sel, exp_rdy});
      check("rand_err_count", err_count, 16'(m_cnt));
      // D side expectation
      if (d_owner >= 0) g = d_owner;
      else if (tv && !ev) g = 0;
      else if (ev && !tv) g = 1;
      else if (tv && ev) g = rr;
      else g = 0;
      exp_dv = (g == 1) ? ev : tv;
      check("rand_d", {bus.auto_in_d_valid, bus.auto_in_d_source, bus.auto_in_d_denied,
                       bus.auto_out_d_ready, bus.auto_err_d_ready},
            {exp_dv, (g == 1) ? 5'd17 : 5'd3, g == 1, (g == 0) & dr, (g == 1) & dr});
      // advance the model to the next edge
      a_fire_m = in_v && exp_rdy;
      if (a_fire_m) begin
        if (a_rem == 0) begin
          a_rem = a_beats(op, sz) - 1;
          a_held_err = err_sel;
          if (err_sel && CNT_EN && m_cnt < 'hFFFF) m_cnt++;
        end else begin
          a_rem--;
        end
      end
      if (exp_dv && dr) begin
        if (d_owner < 0) begin
          d_rem = (g == 1) ? d_beats(eop, esz) - 1 : d_beats(dop, dsz) - 1;
          if (d_rem > 0) d_owner = g;
          else rr = !rr;
        end else begin
          d_rem--;
          if (d_rem == 0) begin
            d_owner = -1;
            rr = !rr;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
